instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter IMEM_WORDS, default 64, giving the instruction-memory depth in 32-bit words (power of two, at least 8).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset (word aligned).
REQ-003 The block SHALL have port CLOCK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-005 The block SHALL have port OUTPUT, output, 32 bits: the instruction code at the current PC.

Function
REQ-006 The block SHALL hold a 32-bit program counter PC, byte-addressed, always word aligned (PC[1:0] = 0).
REQ-007 On each CLOCK rising edge with RESET = 1, PC SHALL become PC + 4.
REQ-008 When PC + 4 equals IMEM_WORDS*4, PC SHALL wrap to 0 on that edge; there is no other PC exception.
REQ-009 Instruction memory SHALL be a read-only, byte-organised array of IMEM_WORDS*4 bytes, indexed by PC[log2(IMEM_WORDS*4)-1:0]; upper PC bits are ignored.
REQ-010 OUTPUT SHALL be the little-endian word {mem[PC+3], mem[PC+2], mem[PC+1], mem[PC]}, read combinationally: zero-cycle latency from PC change, no output register.
REQ-011 Default memory contents SHALL be: byte address 0 = 32'h0050_0093, 4 = 32'h00A0_0113, 8 = 32'h0020_81B3, 12 = 32'h4020_8233, 16 = 32'h0000_0013; every remaining word = 32'h0000_0013 (NOP).
REQ-012 No handshake or stall input exists; fetch advances every enabled cycle.
REQ-013 No X or Z SHALL appear on OUTPUT at any time after time 0.

Reset
REQ-014 While RESET = 0, PC SHALL be forced to RESET_PC immediately (asynchronous), independent of CLOCK.
REQ-015 During reset, OUTPUT SHALL equal the memory word at RESET_PC (32'h0050_0093 with default contents).
REQ-016 After RESET rises, the first rising CLOCK edge SHALL advance PC to RESET_PC + 4.
REQ-017 Reset asserted mid-run SHALL abandon the current PC with no stored fetch history; fetch restarts from RESET_PC.

Structure
REQ-018 A shared package SHALL hold XLEN = 32, INSTR_NOP = 32'h0000_0013, the PC increment 4, and the default-program word constants.
REQ-019 Instruction storage SHALL be one sub-module, instr_mem: a byte array with one address input and one 32-bit combinational read-data output; the top SHALL contain only the PC register, incrementer, and wrap logic.
REQ-020 The design SHALL be synthesisable, with no latches and no delays.

Verification
REQ-021 RESET = 0 at time 0 with CLOCK toggling every 20 time units -> PC = 0 and OUTPUT = 32'h0050_0093, held across the clock edges that occur during reset.
REQ-022 RESET released, then 4 rising edges -> OUTPUT sequence 32'h00A0_0113, 32'h0020_81B3, 32'h4020_8233, 32'h0000_0013.
REQ-023 RESET driven to 0 between clock edges after 5 fetches -> OUTPUT returns to 32'h0050_0093 immediately, before the next edge.
REQ-024 RESET released again -> sequence restarts at byte address 4 (32'h00A0_0113) on the first rising edge.
REQ-025 Hold RESET = 1 for IMEM_WORDS edges from reset (64 with defaults) -> PC wraps to 0 and OUTPUT = 32'h0050_0093.
REQ-026 A scoreboard model of PC SHALL match the DUT every cycle across all of the above scenarios.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit.
// Holds XLEN, the NOP encoding, PC step and the default program image.
package instruction_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;

  localparam logic [XLEN-1:0] PROG_W0 = 32'h0050_0093;
  localparam logic [XLEN-1:0] PROG_W1 = 32'h00A0_0113;
  localparam logic [XLEN-1:0] PROG_W2 = 32'h0020_81B3;
  localparam logic [XLEN-1:0] PROG_W3 = 32'h4020_8233;
  localparam logic [XLEN-1:0] PROG_W4 = 32'h0000_0013;

  function automatic logic [XLEN-1:0] prog_word(input int idx);
    logic [XLEN-1:0] w;
    case (idx)
      0:       w = PROG_W0;
      1:       w = PROG_W1;
      2:       w = PROG_W2;
      3:       w = PROG_W3;
      4:       w = PROG_W4;
      default: w = INSTR_NOP;
    endcase
    return w;
  endfunction

  // Little-endian byte view of the program image
  function automatic logic [7:0] prog_byte(input int a);
    logic [XLEN-1:0] w;
    w = prog_word(a / 4);
    return w[8*(a%4) +: 8];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_instr_mem.sv
// Read-only byte-organised instruction store.
// Combinational little-endian 32-bit read at a byte address.
module instr_mem
  import instruction_fetch_unit_pkg::*;
#(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS*4)
) (
  input  logic [AW-1:0]   addr,
  output logic [XLEN-1:0] rdata
);

  localparam int BYTES = WORDS * 4;

  logic [7:0] mem [BYTES];

  for (genvar g = 0; g < BYTES; g++) begin : g_rom
    assign mem[g] = prog_byte(g);
  end

  always_comb begin
    rdata = {mem[addr + AW'(3)],
             mem[addr + AW'(2)],
             mem[addr + AW'(1)],
             mem[addr]};
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Free-running instruction fetch: PC register, +4 step, wrap.
// Instruction word is read combinationally from instr_mem.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int              IMEM_WORDS = 64,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic            CLOCK,
  input  logic            RESET,
  output logic [XLEN-1:0] OUTPUT
);

  localparam int AW = $clog2(IMEM_WORDS*4);
  localparam logic [XLEN-1:0] WRAP_AT = XLEN'(IMEM_WORDS*4);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_inc;

  always_comb begin
    pc_inc = pc_q + PC_INC;
    pc_d   = pc_inc;
    if (pc_inc == WRAP_AT) pc_d = '0;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  instr_mem #(
    .WORDS (IMEM_WORDS)
  ) u_instr_mem (
    .addr  (pc_q[AW-1:0]),
    .rdata (OUTPUT)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// Scoreboards PC and the fetched word each cycle.
module tb_instruction_fetch_unit;

  logic        CLOCK;
  logic        RESET;
  logic [31:0] OUTPUT;

  int n_run;
  int n_fail;
  logic [31:0] mpc;

  instruction_fetch_unit dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .OUTPUT (OUTPUT)
  );

  initial CLOCK = 1'b0;
  always #20 CLOCK = ~CLOCK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [31:0] w;
    case (pc)
      32'd0:   w = 32'h0050_0093;
      32'd4:   w = 32'h00A0_0113;
      32'd8:   w = 32'h0020_81B3;
      32'd12:  w = 32'h4020_8233;
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  task automatic tick(input string tag);
    @(posedge CLOCK);
    if (RESET) mpc = (mpc + 32'd4 == 32'd256) ? 32'd0 : mpc + 32'd4;
    @(negedge CLOCK);
    chk({tag, "_pc"}, dut.pc_q, mpc);
    chk({tag, "_out"}, OUTPUT, exp_word(mpc));
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    mpc    = 32'd0;
    RESET  = 1'b0;

    #1;
    chk("t0_pc", dut.pc_q, 32'd0);
    chk("t0_out", OUTPUT, 32'h0050_0093);
    repeat (3) tick("in_rst");

    RESET = 1'b1;
    tick("f1");
    chk("seq1", OUTPUT, 32'h00A0_0113);
    tick("f2");
    chk("seq2", OUTPUT, 32'h0020_81B3);
    tick("f3");
    chk("seq3", OUTPUT, 32'h4020_8233);
    tick("f4");
    chk("seq4", OUTPUT, 32'h0000_0013);
    tick("f5");
    chk("pc20", dut.pc_q, 32'd20);

    #5 RESET = 1'b0;
    mpc = 32'd0;
    #1;
    chk("async_pc", dut.pc_q, 32'd0);
    chk("async_out", OUTPUT, 32'h0050_0093);
    @(negedge CLOCK);
    tick("rst2_hold");

    RESET = 1'b1;
    tick("r1");
    chk("restart", OUTPUT, 32'h00A0_0113);
    tick("r2");

    #5 RESET = 1'b0;
    mpc = 32'd0;
    @(negedge CLOCK);
    RESET = 1'b1;
    for (int i = 0; i < 63; i++) tick("run");
    chk("pc_last", dut.pc_q, 32'd252);
    chk("out_last", OUTPUT, 32'h0000_0013);
    tick("wrap");
    chk("wrap_pc", dut.pc_q, 32'd0);
    chk("wrap_out", OUTPUT, 32'h0050_0093);
    tick("post_wrap");
    chk("post_wrap_out", OUTPUT, 32'h00A0_0113);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
